// File: rtl/mem_bus_if.sv
// Memory-stage bus interface: turns one load/store request from the pipeline
// into a single request/response bus transaction with timeout and flush handling.
module mem_bus_if #(
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [2:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_req_o,
    output logic        acc_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

    // Last counter value before the limit; reaching it without progress is a timeout.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            legal;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;
    logic [TO_W-1:0] cnt_d;
    logic            timeout;

    always_comb begin
        legal   = 1'b0;
        be_d    = 4'b0000;
        wdata_d = mem_data_i;
        case (mem_sel_i)
            3'b000: begin
                legal   = 1'b1;
                be_d    = 4'b0001 << mem_addr_i[1:0];
                wdata_d = {4{mem_data_i[7:0]}};
            end
            3'b001: begin
                legal   = ~mem_addr_i[0];
                be_d    = 4'b0011 << {mem_addr_i[1], 1'b0};
                wdata_d = {2{mem_data_i[15:0]}};
            end
            3'b010: begin
                legal   = (mem_addr_i[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = mem_data_i;
            end
            default: begin
                legal   = 1'b0;
                be_d    = 4'b0000;
                wdata_d = mem_data_i;
            end
        endcase
    end

    // Counter saturates so a late grant can never wrap it back below the limit.
    assign cnt_d   = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign timeout = (cnt_q >= TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_ce_i && !flush_i) begin
                        we_q    <= mem_we_i;
                        addr_q  <= {mem_addr_i[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        if (legal) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (bus_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= flush_i ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (timeout) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (flush_i) begin
                        state_q <= DRAIN;
                    end else if (bus_rvalid_i) begin
                        state_q <= DONE;
                        err_q   <= bus_err_i;
                        rdata_q <= (!we_q && !bus_err_i) ? bus_rdata_i : 32'h0;
                    end else if (timeout) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_d;
                    if (bus_rvalid_i || timeout) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_req_o = rst && (((state_q == IDLE) && mem_ce_i) || (state_q == REQ) ||
                                 (state_q == WAIT) || (state_q == DRAIN));
    assign acc_err_o   = (state_q == DONE) && err_q && !flush_i;
    assign mem_rdata_o = rdata_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: vector table, hand-written flush/reset sequences and
// random accesses checked against a transaction-level reference model.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i, flush_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic [2:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        stall_req_o, acc_err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    mem_bus_if #(.TO_W(4)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .flush_i(flush_i),
        .mem_rdata_o(mem_rdata_o), .stall_req_o(stall_req_o), .acc_err_o(acc_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    typedef struct {
        int          stall;
        logic        req_seen;
        logic        bwe;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic        aerr;
        logic        req_at_done;
        logic        aerr_after;
    } obs_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [31:0] data;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic        err;
        int          x_stall;
        logic        x_req;
        logic [31:0] x_baddr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access through the bus: gnt after gd REQ cycles, rvalid after rd WAIT cycles.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [2:0] sel,
                              input logic [31:0] data, input int gd, input int rd,
                              input logic [31:0] rdata, input logic err, output obs_t o);
        int  rc, wc;
        logic granted, finished;
        o.stall = 0; o.req_seen = 0; o.bwe = 0; o.baddr = 0; o.be = 0; o.wdata = 0;
        o.mrdata = 0; o.aerr = 0; o.req_at_done = 0; o.aerr_after = 0;
        rc = 0; wc = 0; granted = 0; finished = 0;
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        #1;
        if (stall_req_o) o.stall++;
        tick();
        mem_ce_i = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (!stall_req_o) begin
                o.mrdata = mem_rdata_o;
                o.aerr = acc_err_o;
                o.req_at_done = bus_req_o;
                finished = 1;
                break;
            end
            o.stall++;
            if (bus_req_o) begin
                o.req_seen = 1; o.bwe = bus_we_o; o.baddr = bus_addr_o;
                o.be = bus_be_o; o.wdata = bus_wdata_o;
                bus_gnt_i = (rc == gd);
                if (rc == gd) granted = 1;
                rc++;
            end else if (granted) begin
                if (wc == rd) begin
                    bus_rvalid_i = 1'b1; bus_rdata_i = rdata; bus_err_i = err;
                end
                wc++;
            end
            tick();
            bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
        end
        if (!finished) begin
            check("access_bound", 32'd1, 32'd0);
            rst = 1'b0; #1; rst = 1'b1;
        end
        tick();
        o.aerr_after = acc_err_o;
    endtask

    // Reference: decide the outcome from the access size, alignment and bus timing.
    function automatic obs_t model(input logic we, input logic [31:0] addr, input logic [2:0] sel,
                                   input logic [31:0] data, input int gd, input int rd,
                                   input logic [31:0] rdata, input logic err);
        obs_t e;
        int size, need;
        size = (sel == 3'd0) ? 1 : (sel == 3'd1) ? 2 : (sel == 3'd2) ? 4 : 0;
        e.stall = 1; e.req_seen = 0; e.bwe = we; e.baddr = addr - 32'(addr % 4);
        e.be = 0; e.wdata = 0; e.mrdata = 0; e.aerr = 1; e.req_at_done = 0; e.aerr_after = 0;
        if (size != 0 && (addr % size) == 0) begin
            e.req_seen = 1;
            e.be = 4'(((1 << size) - 1) << (addr % 4));
            e.wdata = (size == 1) ? 32'(data[7:0]) * 32'h01010101 :
                      (size == 2) ? 32'(data[15:0]) * 32'h00010001 : data;
            need = gd + rd + 2;
            if (need <= 15) begin
                e.stall = 1 + need;
                e.aerr = err;
                e.mrdata = (!we && !err) ? rdata : 32'h0;
            end else begin
                e.stall = 16;
                e.aerr = 1;
            end
        end
        return e;
    endfunction

    task automatic compare(input string tag, input obs_t a, input obs_t e);
        check({tag, ".stall"}, 32'(a.stall), 32'(e.stall));
        check({tag, ".req"}, 32'(a.req_seen), 32'(e.req_seen));
        if (e.req_seen) begin
            check({tag, ".we"}, 32'(a.bwe), 32'(e.bwe));
            check({tag, ".addr"}, a.baddr, e.baddr);
            check({tag, ".be"}, 32'(a.be), 32'(e.be));
            check({tag, ".wdata"}, a.wdata, e.wdata);
        end
        check({tag, ".rdata"}, a.mrdata, e.mrdata);
        check({tag, ".err"}, 32'(a.aerr), 32'(e.aerr));
        check({tag, ".req_done"}, 32'(a.req_at_done), 32'(e.req_at_done));
        check({tag, ".err_after"}, 32'(a.aerr_after), 32'(e.aerr_after));
    endtask

    vec_t vecs[11];
    obs_t ob, ex;
    logic [31:0] held;

    initial begin
        vecs[0]  = '{0, 32'h100, 3'd2, 32'h0,        0, 0,  32'hCAFEBABE, 0, 3,  1, 32'h100, 4'hF, 32'h0,        32'hCAFEBABE, 0};
        vecs[1]  = '{1, 32'h203, 3'd0, 32'h000000A5, 0, 0,  32'h12345678, 0, 3,  1, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0,        0};
        vecs[2]  = '{0, 32'h101, 3'd1, 32'h0,        0, 0,  32'h0,        0, 1,  0, 32'h0,   4'h0, 32'h0,        32'h0,        1};
        vecs[3]  = '{1, 32'h102, 3'd1, 32'hBEEF1234, 2, 1,  32'h0,        0, 6,  1, 32'h100, 4'hC, 32'h12341234, 32'h0,        0};
        vecs[4]  = '{0, 32'h001, 3'd0, 32'h0,        1, 3,  32'h11223344, 0, 7,  1, 32'h0,   4'h2, 32'h0,        32'h11223344, 0};
        vecs[5]  = '{0, 32'h104, 3'd2, 32'h0,        0, 0,  32'h55555555, 1, 3,  1, 32'h104, 4'hF, 32'h0,        32'h0,        1};
        vecs[6]  = '{0, 32'h000, 3'd3, 32'h0,        0, 0,  32'h0,        0, 1,  0, 32'h0,   4'h0, 32'h0,        32'h0,        1};
        vecs[7]  = '{1, 32'h012, 3'd2, 32'h0,        0, 0,  32'h0,        0, 1,  0, 32'h0,   4'h0, 32'h0,        32'h0,        1};
        vecs[8]  = '{0, 32'h300, 3'd2, 32'h0,        99, 0, 32'h0,        0, 16, 1, 32'h300, 4'hF, 32'h0,        32'h0,        1};
        vecs[9]  = '{0, 32'h040, 3'd2, 32'h0,        0, 99, 32'h0,        0, 16, 1, 32'h040, 4'hF, 32'h0,        32'h0,        1};
        vecs[10] = '{0, 32'h044, 3'd2, 32'h0,        3, 10, 32'h5A5A0001, 0, 16, 1, 32'h044, 4'hF, 32'h0,        32'h5A5A0001, 0};

        rst = 1'b0; mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_sel_i = 0; mem_data_i = 0;
        flush_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
        tick(); tick();
        check("rst.req", 32'(bus_req_o), 32'd0);
        check("rst.stall", 32'(stall_req_o), 32'd0);
        check("rst.err", 32'(acc_err_o), 32'd0);
        check("rst.rdata", mem_rdata_o, 32'd0);
        check("rst.addr", bus_addr_o, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, vecs[i].gd,
                       vecs[i].rd, vecs[i].rdata, vecs[i].err, ob);
            ex.stall = vecs[i].x_stall; ex.req_seen = vecs[i].x_req; ex.bwe = vecs[i].we;
            ex.baddr = vecs[i].x_baddr; ex.be = vecs[i].x_be; ex.wdata = vecs[i].x_wdata;
            ex.mrdata = vecs[i].x_rdata; ex.aerr = vecs[i].x_err;
            ex.req_at_done = 0; ex.aerr_after = 0;
            if (vecs[i].x_req == 1'b0) begin
                ex.bwe = 0;
            end
            compare($sformatf("vec%0d", i), ob, ex);
        end

        // Flush while requesting: request drops next cycle, no error.
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h80; mem_sel_i = 3'd2;
        tick();
        mem_ce_i = 0;
        check("flreq.req_on", 32'(bus_req_o), 32'd1);
        flush_i = 1;
        tick();
        flush_i = 0;
        check("flreq.req_off", 32'(bus_req_o), 32'd0);
        check("flreq.stall", 32'(stall_req_o), 32'd0);
        check("flreq.err", 32'(acc_err_o), 32'd0);
        tick();
        check("flreq.err2", 32'(acc_err_o), 32'd0);

        // Flush while waiting: drain the late response, keep the old read data.
        held = mem_rdata_o;
        mem_ce_i = 1; mem_addr_i = 32'h84;
        tick();
        mem_ce_i = 0; bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0; flush_i = 1;
        tick();
        flush_i = 0;
        check("flwait.drain_stall", 32'(stall_req_o), 32'd1);
        check("flwait.req", 32'(bus_req_o), 32'd0);
        bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
        tick();
        bus_rvalid_i = 0; bus_rdata_i = 0;
        check("flwait.idle", 32'(stall_req_o), 32'd0);
        check("flwait.err", 32'(acc_err_o), 32'd0);
        check("flwait.hold", mem_rdata_o, held);
        tick();
        check("flwait.err2", 32'(acc_err_o), 32'd0);

        // Flush in the same cycle as the grant goes to DRAIN.
        mem_ce_i = 1; mem_addr_i = 32'h88;
        tick();
        mem_ce_i = 0; bus_gnt_i = 1; flush_i = 1;
        tick();
        bus_gnt_i = 0; flush_i = 0;
        check("flgnt.stall", 32'(stall_req_o), 32'd1);
        bus_rvalid_i = 1;
        tick();
        bus_rvalid_i = 0;
        check("flgnt.idle", 32'(stall_req_o), 32'd0);
        check("flgnt.err", 32'(acc_err_o), 32'd0);

        // Flush during DONE masks the error pulse.
        mem_ce_i = 1; mem_addr_i = 32'h101; mem_sel_i = 3'd1;
        tick();
        mem_ce_i = 0; flush_i = 1;
        #1;
        check("fldone.err", 32'(acc_err_o), 32'd0);
        check("fldone.rdata", mem_rdata_o, 32'd0);
        check("fldone.req", 32'(bus_req_o), 32'd0);
        tick();
        flush_i = 0;
        check("fldone.err2", 32'(acc_err_o), 32'd0);

        // Reset in WAIT clears everything at once; a later rvalid is ignored.
        mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h203; mem_sel_i = 3'd0; mem_data_i = 32'hA5;
        tick();
        mem_ce_i = 0; bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        check("rstw.we_before", 32'(bus_we_o), 32'd1);
        #1;
        rst = 1'b0; mem_ce_i = 1;
        #1;
        check("rstw.req", 32'(bus_req_o), 32'd0);
        check("rstw.we", 32'(bus_we_o), 32'd0);
        check("rstw.addr", bus_addr_o, 32'd0);
        check("rstw.be", 32'(bus_be_o), 32'd0);
        check("rstw.wdata", bus_wdata_o, 32'd0);
        check("rstw.stall", 32'(stall_req_o), 32'd0);
        check("rstw.err", 32'(acc_err_o), 32'd0);
        mem_ce_i = 0;
        #1;
        rst = 1'b1;
        bus_rvalid_i = 1; bus_rdata_i = 32'h77777777;
        tick();
        bus_rvalid_i = 0; bus_rdata_i = 0;
        check("rstw.post_stall", 32'(stall_req_o), 32'd0);
        check("rstw.post_rdata", mem_rdata_o, 32'd0);
        check("rstw.post_err", 32'(acc_err_o), 32'd0);

        // Random accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic        r_we, r_err;
            logic [31:0] r_addr, r_data, r_rdata;
            logic [2:0]  r_sel;
            int          r_gd, r_rd;
            r_we = 1'($urandom); r_addr = $urandom; r_data = $urandom; r_rdata = $urandom;
            r_sel = 3'($urandom_range(0, 4)); r_err = ($urandom_range(0, 7) == 0);
            r_gd = $urandom_range(0, 4); r_rd = $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            run_access(r_we, r_addr, r_sel, r_data, r_gd, r_rd, r_rdata, r_err, ob);
            ex = model(r_we, r_addr, r_sel, r_data, r_gd, r_rd, r_rdata, r_err);
            compare($sformatf("rnd%0d", i), ob, ex);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
